// File: rtl/matrix_mem_sequencer_pkg.sv
// Shared types and constants for the matrix row load/store sequencer.
// Element i of a row lives at bits [DATA_W*i +: DATA_W].
package matrix_mem_sequencer_pkg;

    localparam int MATRIX_W   = 128;
    localparam int DEF_ELEMS  = 4;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_STRIDE = 4;
    localparam int DEF_IDX_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Lowest bit of element idx inside a row of w-bit words.
    function automatic int word_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/matrix_mem_sequencer_if.sv
// Request, data-memory and completion bundle of the sequencer.
// master = pipeline/memory side, slave = the sequencer.
interface matrix_mem_sequencer_if;
    import matrix_mem_sequencer_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic                req_write;
    logic [31:0]         req_base;
    logic [MATRIX_W-1:0] req_wdata;
    logic                flush;

    logic [31:0]         mem_addr;
    logic [31:0]         mem_wdata;
    logic                mem_r_en;
    logic                mem_w_en;
    logic [31:0]         mem_rdata;

    logic                stall;
    logic                done_valid;
    logic [MATRIX_W-1:0] done_rdata;
    logic                err_misalign;

    modport master (
        output req_valid, req_write, req_base, req_wdata,
        output flush, mem_rdata,
        input  req_ready, mem_addr, mem_wdata,
        input  mem_r_en, mem_w_en,
        input  stall, done_valid, done_rdata, err_misalign
    );

    modport slave (
        input  req_valid, req_write, req_base, req_wdata,
        input  flush, mem_rdata,
        output req_ready, mem_addr, mem_wdata,
        output mem_r_en, mem_w_en,
        output stall, done_valid, done_rdata, err_misalign
    );

endinterface

// File: rtl/matrix_mem_sequencer_row_pack.sv
// Row packer: word-indexed load assembly register and
// word-indexed read mux for store data.
module matrix_row_pack
    import matrix_mem_sequencer_pkg::*;
#(
    parameter int ELEMS  = DEF_ELEMS,
    parameter int DATA_W = DEF_DATA_W,
    parameter int IDX_W  = DEF_IDX_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic [DATA_W-1:0]       wr_word,
    output logic [ELEMS*DATA_W-1:0] row_d,
    input  logic [ELEMS*DATA_W-1:0] rd_row,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic [DATA_W-1:0]       rd_word
);

    logic [ELEMS*DATA_W-1:0] row_q;

    // Merge the incoming word into its slot of the row.
    always_comb begin
        row_d = row_q;
        if (wr_en) begin
            row_d[word_lo(int'(wr_idx), DATA_W) +: DATA_W] = wr_word;
        end
    end

    // Assembly register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q <= '0;
        end else begin
            row_q <= row_d;
        end
    end

    assign rd_word = rd_row[word_lo(int'(rd_idx), DATA_W) +: DATA_W];

endmodule

// File: rtl/matrix_mem_sequencer.sv
// Matrix row load/store sequencer: one row as ELEMS word
// accesses on the memory-stage data port, stalling the pipe.
module matrix_mem_sequencer
    import matrix_mem_sequencer_pkg::*;
#(
    parameter int ELEMS  = DEF_ELEMS,
    parameter int DATA_W = DEF_DATA_W,
    parameter int STRIDE = DEF_STRIDE,
    parameter int IDX_W  = DEF_IDX_W
) (
    input logic                   clk,
    input logic                   rst,
    matrix_mem_sequencer_if.slave bus
);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [31:0]             base_q, base_d;
    logic [MATRIX_W-1:0]     wdata_q, wdata_d;
    logic                    write_q, write_d;
    logic                    err_q, err_d;
    logic [MATRIX_W-1:0]     done_rdata_q, done_rdata_d;

    logic                    accept;
    logic                    misalign;
    logic                    xfer;
    logic                    go;
    logic                    last;
    logic [ELEMS*DATA_W-1:0] asm_d;
    logic [DATA_W-1:0]       rd_word;

    assign accept   = (state_q == ST_IDLE) && bus.req_valid
                      && !bus.flush;
    assign misalign = bus.req_base[1:0] != 2'b00;
    assign xfer     = state_q == ST_XFER;
    assign go       = xfer && !bus.flush;
    assign last     = idx_q == IDX_W'(ELEMS - 1);

    matrix_row_pack #(
        .ELEMS  (ELEMS),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_pack (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (go && !write_q),
        .wr_idx  (idx_q),
        .wr_word (bus.mem_rdata),
        .row_d   (asm_d),
        .rd_row  (wdata_q),
        .rd_idx  (idx_q),
        .rd_word (rd_word)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; a flush in XFER abandons the transfer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept && !misalign) state_d = ST_XFER;
            ST_XFER: begin
                if (bus.flush)  state_d = ST_IDLE;
                else if (last)  state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latch, element counter, error pulse, load result.
    always_comb begin
        idx_d        = idx_q;
        base_d       = base_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        err_d        = 1'b0;
        done_rdata_d = done_rdata_q;
        if (accept) begin
            base_d  = bus.req_base;
            wdata_d = bus.req_wdata;
            write_d = bus.req_write;
            idx_d   = '0;
            err_d   = misalign;
        end
        if (go) begin
            idx_d = idx_q + IDX_W'(1);
            if (last && !write_q) done_rdata_d = asm_d;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q        <= '0;
            base_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            err_q        <= 1'b0;
            done_rdata_q <= '0;
        end else begin
            idx_q        <= idx_d;
            base_q       <= base_d;
            wdata_q      <= wdata_d;
            write_q      <= write_d;
            err_q        <= err_d;
            done_rdata_q <= done_rdata_d;
        end
    end

    // Outputs; the port is driven only while a word moves.
    always_comb begin
        bus.req_ready    = state_q == ST_IDLE;
        bus.stall        = xfer;
        bus.done_valid   = state_q == ST_DONE;
        bus.err_misalign = err_q;
        bus.done_rdata   = done_rdata_q;
        bus.mem_r_en     = go && !write_q;
        bus.mem_w_en     = go && write_q;
        bus.mem_addr     = '0;
        bus.mem_wdata    = '0;
        if (go) begin
            bus.mem_addr = base_q + 32'(idx_q) * 32'(STRIDE);
            if (write_q) bus.mem_wdata = rd_word;
        end
    end

endmodule

// File: tb/tb_matrix_mem_sequencer.sv
// Directed bench for matrix_mem_sequencer: loads, stores,
// misalignment, flush, address wrap and async reset.
module tb_matrix_mem_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    matrix_mem_sequencer_if bus ();

    matrix_mem_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Sparse memory: key folds the few regions used here.
    logic [31:0] mem [32];
    logic        pre_en   = 1'b0;
    logic [31:0] pre_addr = '0;
    logic [31:0] pre_data = '0;

    function automatic logic [4:0] mkey(input logic [31:0] a);
        return {a[31], a[9:8], a[3:2]};
    endfunction

    assign bus.mem_rdata = mem[mkey(bus.mem_addr)];

    // Memory writes from the DUT, or bench preloads.
    always @(posedge clk) begin
        if (bus.mem_w_en)
            mem[mkey(bus.mem_addr)] <= bus.mem_wdata;
        else if (pre_en)
            mem[mkey(pre_addr)] <= pre_data;
    end

    task automatic chk(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a,
                           input logic [31:0] d);
        @(negedge clk);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(negedge clk);
        pre_en   = 1'b0;
    endtask

    task automatic idle_outputs(input string tag);
        chk({tag, " ready"}, 128'(bus.req_ready), 128'd1);
        chk({tag, " stall"}, 128'(bus.stall), 128'd0);
        chk({tag, " r_en"}, 128'(bus.mem_r_en), 128'd0);
        chk({tag, " w_en"}, 128'(bus.mem_w_en), 128'd0);
        chk({tag, " addr"}, 128'(bus.mem_addr), 128'd0);
        chk({tag, " done"}, 128'(bus.done_valid), 128'd0);
    endtask

    // Full transfer with per-cycle checks of the memory port.
    task automatic run_xfer(input string tag,
                            input logic wr,
                            input logic [31:0] base,
                            input logic [127:0] wd,
                            input logic [127:0] exp_rd);
        logic [31:0] ea;
        logic [31:0] ew;
        @(negedge clk);
        chk({tag, " ready"}, 128'(bus.req_ready), 128'd1);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_base  = base;
        bus.req_wdata = wd;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            ea = base + 32'(4 * i);
            ew = wr ? wd[32*i +: 32] : 32'd0;
            chk({tag, " addr"}, 128'(bus.mem_addr), 128'(ea));
            chk({tag, " r_en"}, 128'(bus.mem_r_en), 128'(!wr));
            chk({tag, " w_en"}, 128'(bus.mem_w_en), 128'(wr));
            chk({tag, " wdata"}, 128'(bus.mem_wdata), 128'(ew));
            chk({tag, " stall"}, 128'(bus.stall), 128'd1);
            chk({tag, " ready"}, 128'(bus.req_ready), 128'd0);
            chk({tag, " done"}, 128'(bus.done_valid), 128'd0);
        end
        @(negedge clk);
        chk({tag, " done"}, 128'(bus.done_valid), 128'd1);
        chk({tag, " dstall"}, 128'(bus.stall), 128'd0);
        chk({tag, " dren"}, 128'(bus.mem_r_en), 128'd0);
        chk({tag, " dwen"}, 128'(bus.mem_w_en), 128'd0);
        chk({tag, " dready"}, 128'(bus.req_ready), 128'd0);
        chk({tag, " rdata"}, bus.done_rdata, exp_rd);
        @(negedge clk);
        chk({tag, " post"}, 128'(bus.done_valid), 128'd0);
        chk({tag, " pready"}, 128'(bus.req_ready), 128'd1);
    endtask

    localparam logic [127:0] LD1 =
        128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] ST1 =
        128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    localparam logic [127:0] WRP =
        128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0;
    localparam logic [127:0] FLS =
        128'h99999999_88888888_77777777_66666666;

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_base  = '0;
        bus.req_wdata = '0;
        bus.flush     = 1'b0;

        // Reset state.
        #12;
        idle_outputs("rst");
        chk("rst rdata", bus.done_rdata, 128'd0);
        chk("rst err", 128'(bus.err_misalign), 128'd0);
        rst = 1'b1;

        preload(32'h100, 32'h11111111);
        preload(32'h104, 32'h22222222);
        preload(32'h108, 32'h33333333);
        preload(32'h10C, 32'h44444444);
        preload(32'hFFFFFFF8, 32'hA0A0A0A0);
        preload(32'hFFFFFFFC, 32'hB1B1B1B1);
        preload(32'h0, 32'hC2C2C2C2);
        preload(32'h4, 32'hD3D3D3D3);
        preload(32'h300, 32'h5A5A5A5A);
        preload(32'h304, 32'h5A5A5A5A);
        preload(32'h308, 32'h5A5A5A5A);
        preload(32'h30C, 32'h5A5A5A5A);

        // Load, store, then read the stored row back.
        run_xfer("ld", 1'b0, 32'h100, '0, LD1);
        run_xfer("st", 1'b1, 32'h200, ST1, LD1);
        chk("st m0", 128'(mem[mkey(32'h200)]), 128'hAAAAAAAA);
        chk("st m3", 128'(mem[mkey(32'h20C)]), 128'hDDDDDDDD);
        run_xfer("rb", 1'b0, 32'h200, '0, ST1);

        // Misaligned request is rejected with a pulse.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_base  = 32'h102;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("mis err", 128'(bus.err_misalign), 128'd1);
        idle_outputs("mis");
        @(negedge clk);
        chk("mis err2", 128'(bus.err_misalign), 128'd0);
        idle_outputs("mis2");
        chk("mis rdata", bus.done_rdata, ST1);

        // Aligned load right after, crossing the address wrap.
        run_xfer("wrap", 1'b0, 32'hFFFFFFF8, '0, WRP);

        // Store flushed while idx=2.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_base  = 32'h300;
        bus.req_wdata = FLS;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("fl w0", 128'(bus.mem_w_en), 128'd1);
        @(negedge clk);
        chk("fl a1", 128'(bus.mem_addr), 128'h304);
        @(negedge clk);
        bus.flush = 1'b1;
        #1;
        chk("fl wen", 128'(bus.mem_w_en), 128'd0);
        chk("fl addr", 128'(bus.mem_addr), 128'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        idle_outputs("fl");
        @(negedge clk);
        chk("fl done", 128'(bus.done_valid), 128'd0);
        chk("fl rdata", bus.done_rdata, WRP);
        chk("fl m0", 128'(mem[mkey(32'h300)]), 128'h66666666);
        chk("fl m1", 128'(mem[mkey(32'h304)]), 128'h77777777);
        chk("fl m2", 128'(mem[mkey(32'h308)]), 128'h5A5A5A5A);
        chk("fl m3", 128'(mem[mkey(32'h30C)]), 128'h5A5A5A5A);

        // Async reset in the middle of a load.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_base  = 32'h100;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("ar pre", 128'(bus.stall), 128'd1);
        rst = 1'b0;
        #1;
        idle_outputs("ar");
        chk("ar rdata", bus.done_rdata, 128'd0);
        #3;
        rst = 1'b1;
        run_xfer("ar ld", 1'b0, 32'h100, '0, LD1);

        $display("[TB] %0d tests run, %0d failed",
                 n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_mem_sequencer.md
Name: matrix_mem_sequencer

Overview:
Sequences one 128-bit matrix load or store (matrix-register row, ELEMS x 32-bit) as ELEMS back-to-back 32-bit word accesses on the data-memory port of the memory stage. The block owns that port for the duration of a transfer and raises a pipeline stall. On a load it assembles the words into one 128-bit result for matrix writeback.

Parameters:
ELEMS, 4, words per matrix row; DATA_W*ELEMS must equal the 128-bit matrix width
DATA_W, 32, word width
STRIDE, 4, byte step between consecutive word addresses
IDX_W, 2, element-counter width, equal to clog2(ELEMS)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset, asynchronous, active-low
req_valid  in  1  matrix transfer request
req_ready  out  1  high only in IDLE
req_write  in  1  1 = store row to memory, 0 = load row
req_base  in  32  byte address of element 0
req_wdata  in  128  store data; element i = bits [32*i+31 -: 32]
flush  in  1  abort the current transfer (pipeline flush)
mem_addr  out  32  word address to data memory
mem_wdata  out  32  word write data
mem_r_en  out  1  read enable
mem_w_en  out  1  write enable
mem_rdata  in  32  read data, combinational: valid in the same cycle as mem_addr/mem_r_en
stall  out  1  freezes upstream pipeline stages
done_valid  out  1  one-cycle pulse when a transfer completes
done_rdata  out  128  assembled load data; held until the next load completes
err_misalign  out  1  one-cycle pulse when a request is rejected

Behaviour:
- States: IDLE, XFER, DONE. Reset forces IDLE.
- Reset values: idx=0; mem_r_en, mem_w_en, stall, done_valid and err_misalign = 0; done_rdata = 0; latched base, wdata and write flag = 0. mem_addr and mem_wdata are 0 whenever no enable is active.
- IDLE:
  - req_ready=1.
  - Accept when req_valid=1 and flush=0: latch base, wdata and write flag; set idx=0.
  - If req_base[1:0]!=0: no memory access, pulse err_misalign on the next cycle, stay in IDLE.
  - Otherwise go to XFER.
  - If req_valid and flush are both high, the request is dropped.
- XFER (one word per cycle):
  - mem_addr = base + idx*STRIDE, computed modulo 2^32 (addresses wrap).
  - mem_r_en = !write; mem_w_en = write; mem_wdata = wdata element idx.
  - On a load, mem_rdata is captured into element idx of an internal assembly register at the clock edge.
  - idx increments each cycle. After idx=ELEMS-1, go to DONE.
  - stall=1 throughout XFER.
- DONE (1 cycle):
  - done_valid=1, stall=0.
  - On a load, done_rdata = the assembled register (all ELEMS words). On a store, done_rdata is unchanged.
  - Next state is IDLE. A request is not accepted in DONE; req_ready=0.
- Latency: request accepted at edge 0 → XFER cycles 1..ELEMS → done_valid in cycle ELEMS+1 (cycle 5 for the defaults). Throughput is one transfer per ELEMS+2 cycles.
- flush in XFER:
  - Takes effect in that same cycle: enables are forced to 0 in the cycle flush is high.
  - Next state is IDLE, with no done_valid and no change to done_rdata.
  - Stores already committed to earlier words are not rolled back.
- flush in DONE: done_valid is still asserted; the transfer is complete.
- Reset mid-transfer: the asynchronous return to IDLE drops all enables immediately.
- mem_r_en and mem_w_en are never high together. No enable is ever high outside XFER.

Decomposition:
- Shared package/define file:
  - state encodings: ST_IDLE=2'd0, ST_XFER=2'd1, ST_DONE=2'd2
  - MATRIX_W=128
  - the word-select slice convention
- Sub-module: matrix_row_pack.
  - Element-indexed write into a 128-bit register (load assembly), one word per cycle.
  - Element-indexed read mux for store data.
  - The FSM and address generation stay in the top block.

Test Plan:
- Load:
  - Stimulus: memory words 0x100..0x10C = 0x11111111, 0x22222222, 0x33333333, 0x44444444; load req_base=0x100.
  - Response: mem_addr 0x100, 0x104, 0x108, 0x10C on cycles 1–4 with mem_r_en=1; stall=1 on cycles 1–4; done_valid in cycle 5; done_rdata = 0x44444444_33333333_22222222_11111111.
- Store:
  - Stimulus: req_wdata = 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, req_base=0x200.
  - Response: writes of 0xAAAAAAAA, 0xBBBBBBBB, 0xCCCCCCCC, 0xDDDDDDDD to 0x200, 0x204, 0x208, 0x20C; read-back matches; done_rdata unchanged.
- Misaligned request:
  - Stimulus: req_base=0x102.
  - Response: err_misalign pulse one cycle later; no enable ever asserts; stall stays 0; next aligned request proceeds normally.
- Flush mid-store:
  - Stimulus: flush asserted in XFER cycle with idx=2.
  - Response: words 0 and 1 written, words 2 and 3 untouched; no done_valid; req_ready=1 on the next cycle.
- Address wrap:
  - Stimulus: load with req_base=0xFFFFFFF8.
  - Response: addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
- Async reset mid-transfer:
  - Stimulus: rst driven low for half a cycle during XFER.
  - Response: enables, stall and done_valid drop immediately with no clock edge; done_rdata=0; a new request is accepted after rst returns high.
